// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// One digit is selected at a time; each digit slot lasts 2^SCAN_DIV_BITS
// clocks, and a full scan of all digits is one frame.
//
// The game/status logic writes new content into a shadow buffer with a
// single-cycle load strobe. That content is copied into the active (displayed)
// buffer only at a frame boundary, so a frame is never torn. A load that lands
// exactly on the frame boundary bypasses the shadow and goes straight to the
// active buffer.
//
// Other display features:
//   - per-digit enable and decimal-point masks (buffered with the digits);
//   - leading-zero blanking (live level input);
//   - 16-level PWM brightness within each digit slot (live level input).
//
// Ports:
//   ClkPort     in   system clock
//   Reset       in   asynchronous, active-high reset
//   value       in   4*NUM_DIGITS hex nibbles, digit 0 is the rightmost
//   dp_in       in   decimal point request per digit, 1 = lit
//   digit_en    in   per-digit enable, 0 = digit dark
//   load        in   single-cycle strobe capturing value/dp_in/digit_en
//   lz_blank    in   1 = blank leading zero digits
//   brightness  in   PWM duty, lit fraction (brightness+1)/16
//   anode       out  active-low digit selects
//   cathode     out  active-low segments {a,b,c,d,e,f,g}
//   dp          out  active-low decimal point
//   frame_tick  out  one-cycle pulse the cycle after each frame wrap
//   pending     out  1 = shadow holds content not yet displayed
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_tick,
    output logic                    pending
);

    // A single digit still needs a 1-bit index so the select logic stays uniform.
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [SCAN_DIV_BITS-1:0] r_prescaler;
    logic [IDX_W-1:0]         r_index;
    logic                     r_frameTick;

    // Double buffer
    logic [4*NUM_DIGITS-1:0]  r_shadowVal;
    logic [NUM_DIGITS-1:0]    r_shadowDp;
    logic [NUM_DIGITS-1:0]    r_shadowEn;
    logic [4*NUM_DIGITS-1:0]  r_activeVal;
    logic [NUM_DIGITS-1:0]    r_activeDp;
    logic [NUM_DIGITS-1:0]    r_activeEn;
    logic                     r_pending;

    // Registered pin drivers
    logic [NUM_DIGITS-1:0]    r_anode;
    logic [6:0]               r_cathode;
    logic                     r_dp;

    // Combinational helpers
    logic                     w_digitTick;
    logic                     w_frameBoundary;
    logic [NUM_DIGITS-1:0]    w_blank;
    logic                     w_zeroRun;
    logic [3:0]               w_curNibble;
    logic                     w_curEn;
    logic                     w_curDp;
    logic                     w_curBlank;
    logic                     w_pwmOn;
    logic                     w_lit;
    logic [NUM_DIGITS-1:0]    w_anodeNext;

    // Hex to active-low {a,b,c,d,e,f,g} segment pattern.
    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // The slot ends on the last prescaler count; the frame ends when that
    // happens on the last digit.
    assign w_digitTick     = &r_prescaler;
    assign w_frameBoundary = w_digitTick && (r_index == LAST_IDX);

    // Free-running prescaler and digit index.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_prescaler <= '0;
            r_index     <= '0;
            r_frameTick <= 1'b0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
            r_frameTick <= w_frameBoundary;
            if (w_digitTick) begin
                if (r_index == LAST_IDX) begin
                    r_index <= '0;
                end else begin
                    r_index <= r_index + 1'b1;
                end
            end
        end
    end

    // Shadow/active buffers. The active copy changes only on the frame
    // boundary; a load on that very cycle wins over the older shadow content.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_shadowVal <= '0;
            r_shadowDp  <= '0;
            r_shadowEn  <= '0;
            r_activeVal <= '0;
            r_activeDp  <= '0;
            r_activeEn  <= '0;
            r_pending   <= 1'b0;
        end else if (w_frameBoundary) begin
            if (load) begin
                r_activeVal <= value;
                r_activeDp  <= dp_in;
                r_activeEn  <= digit_en;
                r_pending   <= 1'b0;
            end else if (r_pending) begin
                r_activeVal <= r_shadowVal;
                r_activeDp  <= r_shadowDp;
                r_activeEn  <= r_shadowEn;
                r_pending   <= 1'b0;
            end
        end else if (load) begin
            r_shadowVal <= value;
            r_shadowDp  <= dp_in;
            r_shadowEn  <= digit_en;
            r_pending   <= 1'b1;
        end
    end

    // Leading-zero blanking: walk down from the most significant digit while
    // every nibble seen so far is zero. Digit 0 is never blanked.
    always_comb begin
        w_blank   = '0;
        w_zeroRun = lz_blank;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zeroRun  = w_zeroRun && (r_activeVal[4*i +: 4] == 4'h0);
            w_blank[i] = w_zeroRun;
        end
    end

    // Select the currently scanned digit's content.
    always_comb begin
        w_curNibble = 4'h0;
        w_curEn     = 1'b0;
        w_curDp     = 1'b0;
        w_curBlank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_curNibble = r_activeVal[4*i +: 4];
                w_curEn     = r_activeEn[i];
                w_curDp     = r_activeDp[i];
                w_curBlank  = w_blank[i];
            end
        end
    end

    // PWM uses the top four prescaler bits, so the lit window is always at
    // the start of each slot.
    assign w_pwmOn = (r_prescaler[SCAN_DIV_BITS-1 -: 4] <= brightness);
    assign w_lit   = w_curEn && !w_curBlank && w_pwmOn;

    // One-hot-low anode pattern; at most one bit can ever be low.
    always_comb begin
        w_anodeNext = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_lit && (r_index == IDX_W'(i))) begin
                w_anodeNext[i] = 1'b0;
            end
        end
    end

    // Registered pin stage: everything dark unless the scanned digit is lit.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_anode   <= '1;
            r_cathode <= 7'h7F;
            r_dp      <= 1'b1;
        end else begin
            r_anode   <= w_anodeNext;
            r_cathode <= w_lit ? segDecode(w_curNibble) : 7'h7F;
            r_dp      <= w_lit ? ~w_curDp : 1'b1;
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign dp         = r_dp;
    assign frame_tick = r_frameTick;
    assign pending    = r_pending;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//
// Bench for ssd_scan_driver with 4 digits and 16-clock slots (64-clock
// frames). A bench-side cycle counter, cleared by the same reset, gives the
// frame phase; inputs are driven and outputs sampled on the falling edge.
// At a falling edge with phase q, the pins reflect slot position q-1, so digit
// d at prescaler p is observed at phase 16*d+p+1. A load driven at phase 63
// coincides with the frame boundary.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int ND  = 4;
    localparam int SDB = 4;

    logic          ClkPort = 1'b0;
    logic          Reset   = 1'b1;
    logic [15:0]   value   = '0;
    logic [3:0]    dp_in   = '0;
    logic [3:0]    digit_en = '0;
    logic          load    = 1'b0;
    logic          lz_blank = 1'b0;
    logic [3:0]    brightness = 4'hF;
    logic [3:0]    anode;
    logic [6:0]    cathode;
    logic          dp;
    logic          frame_tick;
    logic          pending;

    int checks = 0;
    int errors = 0;
    int cyc;

    // One table entry: what to load and what each digit should then show.
    // expCat holds {digit3, digit2, digit1, digit0} segment codes.
    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpIn;
        logic [3:0]  en;
        logic        lz;
        logic [3:0]  bright;
        logic [3:0]  expLit;
        logic [27:0] expCat;
        logic [3:0]  expDpLow;
    } vec_t;

    vec_t vecs[9];

    ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB)) dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    always #5 ClkPort = ~ClkPort;

    // Phase reference: counts clocks since reset release.
    always @(posedge ClkPort or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge where the frame phase equals target.
    task automatic waitPhase(input int target);
        int n = 0;
        do begin
            @(negedge ClkPort);
            n++;
        end while (((cyc % 64) != target) && (n < 200));
        if ((cyc % 64) != target) checkVal("waitPhase", 32'(cyc % 64), 32'(target));
    endtask

    task automatic checkDark(input string name);
        checkVal(name, {20'h0, anode, cathode, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
    endtask

    task automatic checkOutput(input string name, input int d, input int p,
                               input logic lit, input logic [6:0] cat, input logic dpLow);
        logic [3:0] expA;
        logic [6:0] expC;
        logic       expD;
        waitPhase((16*d + p + 1) % 64);
        expA = lit ? ~(4'b0001 << d) : 4'hF;
        expC = lit ? cat : 7'h7F;
        expD = (lit && dpLow) ? 1'b0 : 1'b1;
        checkVal($sformatf("%s d%0d p%0d", name, d, p),
                 {20'h0, anode, cathode, dp}, {20'h0, expA, expC, expD});
    endtask

    // Load a table entry mid-frame, then check every digit in the next frame
    // at the start of its slot and around the PWM cut-off.
    task automatic applyStimulus(input vec_t v, input int idx, input logic prevDark);
        string nm;
        nm = $sformatf("vec%0d", idx);
        waitPhase(20);
        value      = v.val;
        dp_in      = v.dpIn;
        digit_en   = v.en;
        lz_blank   = v.lz;
        brightness = v.bright;
        load       = 1'b1;
        @(negedge ClkPort);
        load = 1'b0;
        checkVal({nm, " pending set"}, 32'(pending), 32'd1);
        if (prevDark) begin
            waitPhase(40);
            checkDark({nm, " unchanged before wrap"});
        end
        waitPhase(0);
        checkVal({nm, " pending clear"}, 32'(pending), 32'd0);
        checkVal({nm, " frame_tick"}, 32'(frame_tick), 32'd1);
        for (int d = 0; d < ND; d++) begin
            checkOutput(nm, d, 0, v.expLit[d], v.expCat[7*d +: 7], v.expDpLow[d]);
            if (v.bright != 4'd0)
                checkOutput(nm, d, int'(v.bright), v.expLit[d], v.expCat[7*d +: 7], v.expDpLow[d]);
            if (v.bright != 4'd15)
                checkOutput(nm, d, int'(v.bright) + 1, 1'b0, 7'h7F, 1'b0);
        end
    endtask

    initial begin
        // val, dpIn, en, lz, bright, expLit, expCat {d3,d2,d1,d0}, expDpLow
        vecs[0] = '{16'h12AB, 4'b0100, 4'hF, 1'b0, 4'd15, 4'b1111,
                    {7'b1001111, 7'b0010010, 7'b0001000, 7'b1100000}, 4'b0100};
        vecs[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 4'd15, 4'b0011,
                    {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 4'd15, 4'b0001,
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b0000};
        vecs[3] = '{16'h12AB, 4'b0000, 4'hF, 1'b0, 4'd3, 4'b1111,
                    {7'b1001111, 7'b0010010, 7'b0001000, 7'b1100000}, 4'b0000};
        vecs[4] = '{16'h9C4E, 4'b0001, 4'hF, 1'b0, 4'd0, 4'b1111,
                    {7'b0000100, 7'b0110001, 7'b1001100, 7'b0110000}, 4'b0001};
        vecs[5] = '{16'h8765, 4'b1111, 4'b1010, 1'b0, 4'd15, 4'b1010,
                    {7'b0000000, 7'h7F, 7'b0100000, 7'h7F}, 4'b1010};
        vecs[6] = '{16'h00D0, 4'b1111, 4'hF, 1'b1, 4'd7, 4'b0011,
                    {7'h7F, 7'h7F, 7'b1000010, 7'b0000001}, 4'b0011};
        vecs[7] = '{16'h0307, 4'b0000, 4'hF, 1'b1, 4'd15, 4'b0111,
                    {7'h7F, 7'b0000110, 7'b0000001, 7'b0001111}, 4'b0000};
        vecs[8] = '{16'hF0F0, 4'b0000, 4'hF, 1'b0, 4'd15, 4'b1111,
                    {7'b0111000, 7'b0000001, 7'b0111000, 7'b0000001}, 4'b0000};

        $display("[TB] start");

        // Reset state and idle scanning with nothing loaded.
        repeat (3) @(negedge ClkPort);
        checkVal("reset pins", {16'h0, anode, cathode, dp, pending, frame_tick},
                 {16'h0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        Reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ClkPort);
            checkVal($sformatf("idle c%0d", cyc), {16'h0, anode, cathode, dp, pending, frame_tick},
                     {16'h0, 4'hF, 7'h7F, 1'b1, 1'b0, ((cyc % 64) == 0)});
        end

        // Table of loads: decode, masks, blanking, brightness.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i, (i == 0));
        end

        // Repeated loads while pending, then a load on the frame boundary.
        dp_in = 4'b0000; digit_en = 4'hF; lz_blank = 1'b0; brightness = 4'd15;
        waitPhase(10);
        value = 16'h1111; load = 1'b1;
        @(negedge ClkPort);
        load = 1'b0;
        checkVal("double pending", 32'(pending), 32'd1);
        waitPhase(30);
        value = 16'h2222; load = 1'b1;
        @(negedge ClkPort);
        load = 1'b0;
        waitPhase(63);
        value = 16'h3333; load = 1'b1;
        @(negedge ClkPort);
        load = 1'b0;
        checkVal("bypass pending", 32'(pending), 32'd0);
        checkVal("bypass frame_tick", 32'(frame_tick), 32'd1);
        checkOutput("bypass", 0, 0, 1'b1, 7'b0000110, 1'b0);
        checkOutput("bypass", 3, 0, 1'b1, 7'b0000110, 1'b0);

        // Mid-frame load must not disturb the frame being shown.
        waitPhase(5);
        value = 16'h4444; load = 1'b1;
        @(negedge ClkPort);
        load = 1'b0;
        checkVal("midframe pending", 32'(pending), 32'd1);
        checkOutput("midframe hold", 1, 0, 1'b1, 7'b0000110, 1'b0);
        checkOutput("midframe hold", 3, 0, 1'b1, 7'b0000110, 1'b0);
        checkOutput("midframe new", 0, 0, 1'b1, 7'b1001100, 1'b0);

        // Asynchronous reset while digit 2 is lit.
        checkOutput("pre-reset", 2, 4, 1'b1, 7'b1001100, 1'b0);
        #2 Reset = 1'b1;
        #1;
        checkVal("async reset", {16'h0, anode, cathode, dp, pending, frame_tick},
                 {16'h0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge ClkPort);
        Reset = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge ClkPort);
            checkVal($sformatf("post-reset c%0d", cyc), {16'h0, anode, cathode, dp, pending, frame_tick},
                     {16'h0, 4'hF, 7'h7F, 1'b1, 1'b0, ((cyc % 64) == 0)});
        end
        // First lit digit after the restart must be digit 0.
        applyStimulus(vecs[0], 9, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
